spike_interval_classifier: RTL and testbench

Downstream consumer of the IN_V2_Char neuron's `spike` output. It converts the spike train driven by the ECG current into beat events and measures the inter-spike interval (ISI) in clock cycles. It keeps a 4-beat running average and flags rate class (normal/brady/tachy), irregular rhythm and asystole. Its outputs feed the ECG monitor/readout stage.

---
 rtl/ecg_pkg.sv | 31 +++
 rtl/isi_avg4.sv | 45 ++++
 rtl/spike_interval_classifier.sv | 148 ++++++++++++++
 tb/tb_spike_interval_classifier.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// Shared encodings for the ECG spike-interval classifier: rate classes,
// FSM states and the averaging window geometry.
package ecg_pkg;

    localparam logic [1:0] RC_NONE   = 2'b00;
    localparam logic [1:0] RC_NORMAL = 2'b01;
    localparam logic [1:0] RC_BRADY  = 2'b10;
    localparam logic [1:0] RC_TACHY  = 2'b11;

    // Averaging window: depth and the matching divide shift.
    localparam int AVG_DEPTH = 4;
    localparam int AVG_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRACT = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // Both thresholds are exclusive: an interval equal to either is normal.
    function automatic logic [1:0] rate_of(input logic [31:0] val,
                                           input logic [31:0] tachy,
                                           input logic [31:0] brady);
        if (val < tachy)
            return RC_TACHY;
        else if (val > brady)
            return RC_BRADY;
        return RC_NORMAL;
    endfunction

endpackage

// File: rtl/isi_avg4.sv
// Four-entry interval history with a running sum; the average is the sum
// divided by four, flagged valid once four intervals have been loaded.
module isi_avg4
    import ecg_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             CLK,
    input  logic             KEY,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic [CNT_W-1:0] o_avg,
    output logic             o_avg_valid
);

    logic [AVG_DEPTH-1:0][CNT_W-1:0] r_hist;
    logic [CNT_W+1:0]                r_sum;
    logic [2:0]                      r_fill;
    logic [CNT_W+1:0]                w_sum_nxt;

    // Empty slots hold zero, so subtracting the oldest entry is safe while filling.
    assign w_sum_nxt = r_sum + {2'b00, i_val} - {2'b00, r_hist[AVG_DEPTH-1]};

    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY) begin
            r_hist <= '0;
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_load) begin
            r_hist <= {r_hist[AVG_DEPTH-2:0], i_val};
            r_sum  <= w_sum_nxt;
            if (r_fill != 3'(AVG_DEPTH))
                r_fill <= r_fill + 3'd1;
        end
    end

    assign o_avg       = r_sum[CNT_W+1:AVG_SHIFT];
    assign o_avg_valid = (r_fill == 3'(AVG_DEPTH));

endmodule

// File: rtl/spike_interval_classifier.sv
// Turns the neuron spike train into beat events, measures inter-spike
// intervals and classifies rate, rhythm regularity and asystole.
module spike_interval_classifier
    import ecg_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int REFRACT_CYC = 50,
    parameter int TACHY_ISI   = 300,
    parameter int BRADY_ISI   = 1000,
    parameter int TIMEOUT     = 4000
)(
    input  logic             CLK,
    input  logic             KEY,
    input  logic             spike,
    output logic [CNT_W-1:0] isi,
    output logic             isi_valid,
    output logic [CNT_W-1:0] isi_avg,
    output logic             avg_valid,
    output logic [1:0]       rate_class,
    output logic             irregular,
    output logic             asystole,
    output logic [15:0]      beat_cnt
);

    localparam logic [CNT_W-1:0] L_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_REFR_END = CNT_W'(REFRACT_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_spike_d;
    logic [CNT_W-1:0] r_cnt;

    logic             w_edge;
    logic             w_cnt_at_to;
    logic             w_accept;
    logic             w_isi_load;
    logic             w_timeout;

    logic [CNT_W-1:0] w_avg_prev;
    logic             w_avg_valid_prev;
    logic [CNT_W:0]   w_diff;
    logic             w_irr;

    // spike_d resets low so a spike held across reset release is a new edge.
    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY)
            r_spike_d <= 1'b0;
        else
            r_spike_d <= spike;
    end

    assign w_edge      = spike & ~r_spike_d;
    assign w_cnt_at_to = (r_cnt == L_TIMEOUT);

    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_edge) w_state_nxt = ST_REFRACT;
            ST_REFRACT: if (r_cnt == L_REFR_END) w_state_nxt = ST_MEASURE;
            ST_MEASURE: begin
                if (w_edge)
                    w_state_nxt = ST_REFRACT;
                else if (w_cnt_at_to)
                    w_state_nxt = ST_IDLE;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // A beat landing on the timeout cycle wins over the asystole declaration.
    always_comb begin
        w_accept   = 1'b0;
        w_isi_load = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            ST_IDLE:    w_accept = w_edge;
            ST_MEASURE: begin
                w_accept   = w_edge;
                w_isi_load = w_edge;
                w_timeout  = ~w_edge & w_cnt_at_to;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= CNT_W'(1);
        else if (w_timeout || r_state == ST_IDLE)
            r_cnt <= '0;
        else if (!w_cnt_at_to)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    isi_avg4 #(.CNT_W(CNT_W)) u_avg (
        .CLK         (CLK),
        .KEY         (KEY),
        .i_clr       (w_timeout),
        .i_load      (w_isi_load),
        .i_val       (r_cnt),
        .o_avg       (w_avg_prev),
        .o_avg_valid (w_avg_valid_prev)
    );

    assign isi_avg   = w_avg_prev;
    assign avg_valid = w_avg_valid_prev;

    // Rhythm check uses the average as it stood before this interval is folded in.
    assign w_diff = (r_cnt >= w_avg_prev) ? ({1'b0, r_cnt} - {1'b0, w_avg_prev})
                                          : ({1'b0, w_avg_prev} - {1'b0, r_cnt});
    assign w_irr  = w_avg_valid_prev && (w_diff > {1'b0, (w_avg_prev >> AVG_SHIFT)});

    always_ff @(posedge CLK or posedge KEY) begin
        if (KEY) begin
            isi        <= '0;
            isi_valid  <= 1'b0;
            rate_class <= RC_NONE;
            irregular  <= 1'b0;
            asystole   <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            isi_valid <= w_isi_load;
            if (w_isi_load) begin
                isi        <= r_cnt;
                rate_class <= rate_of(32'(r_cnt), 32'(TACHY_ISI), 32'(BRADY_ISI));
                irregular  <= w_irr;
            end
            if (w_accept) begin
                beat_cnt <= beat_cnt + 16'd1;
                asystole <= 1'b0;
            end
            if (w_timeout) begin
                asystole   <= 1'b1;
                rate_class <= RC_NONE;
            end
        end
    end

endmodule

// File: tb/tb_spike_interval_classifier.sv
// Bench for spike_interval_classifier: a table of beat spacings with
// hand-derived expectations, scoreboarded on isi_valid, plus corner sequences.
module tb_spike_interval_classifier;

    localparam int CNT_W = 16;
    localparam int PW    = 3;

    logic             CLK   = 1'b0;
    logic             KEY   = 1'b0;
    logic             spike = 1'b0;
    logic [CNT_W-1:0] isi;
    logic             isi_valid;
    logic [CNT_W-1:0] isi_avg;
    logic             avg_valid;
    logic [1:0]       rate_class;
    logic             irregular;
    logic             asystole;
    logic [15:0]      beat_cnt;

    spike_interval_classifier #(
        .CNT_W(CNT_W), .REFRACT_CYC(50), .TACHY_ISI(300), .BRADY_ISI(1000), .TIMEOUT(4000)
    ) dut (
        .CLK(CLK), .KEY(KEY), .spike(spike),
        .isi(isi), .isi_valid(isi_valid), .isi_avg(isi_avg), .avg_valid(avg_valid),
        .rate_class(rate_class), .irregular(irregular), .asystole(asystole),
        .beat_cnt(beat_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int gap; bit v; int isi; int rc; bit irr; bit av; int avg; int beat;
    } rec_t;

    typedef struct {
        int isi; int rc; bit irr; bit av; int avg; int beat; int cyc;
    } exp_t;

    rec_t tbl[22];
    exp_t sb[$];
    exp_t mon_e;
    bit   mon_v;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_isi"},        isi,        0);
        chk({tag, "_isi_valid"},  isi_valid,  0);
        chk({tag, "_isi_avg"},    isi_avg,    0);
        chk({tag, "_avg_valid"},  avg_valid,  0);
        chk({tag, "_rate_class"}, rate_class, 0);
        chk({tag, "_irregular"},  irregular,  0);
        chk({tag, "_asystole"},   asystole,   0);
        chk({tag, "_beat_cnt"},   beat_cnt,   0);
    endtask

    // Rise spike r.gap cycles after the previous rise, hold it PW cycles.
    task automatic do_beat(input rec_t r, input string tag);
        exp_t e;
        if (r.gap > PW) repeat (r.gap - PW) @(negedge CLK);
        if (r.v) begin
            e = '{r.isi, r.rc, r.irr, r.av, r.avg, r.beat, cyc + 1};
            sb.push_back(e);
        end
        spike = 1'b1;
        repeat (PW) @(negedge CLK);
        spike = 1'b0;
        chk({tag, "_beat_cnt"}, beat_cnt, r.beat);
    endtask

    // isi_valid must appear exactly on the cycle the scoreboard head names.
    always @(negedge CLK) begin
        if (!KEY) begin
            mon_v = (sb.size() != 0) && (sb[0].cyc == cyc);
            if (mon_v || isi_valid) begin
                chk("isi_valid", isi_valid, mon_v);
                if (mon_v) begin
                    mon_e = sb.pop_front();
                    chk("sb_isi",        isi,        mon_e.isi);
                    chk("sb_rate_class", rate_class, mon_e.rc);
                    chk("sb_irregular",  irregular,  mon_e.irr);
                    chk("sb_avg_valid",  avg_valid,  mon_e.av);
                    chk("sb_isi_avg",    isi_avg,    mon_e.avg);
                    chk("sb_beat_cnt",   beat_cnt,   mon_e.beat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        rec_t r;
        //          gap  v  isi  rc irr av avg beat
        tbl[0]  = '{0,    0, 0,    0, 0, 0, 0,   1};
        tbl[1]  = '{500,  1, 500,  1, 0, 0, 125, 2};
        tbl[2]  = '{500,  1, 500,  1, 0, 0, 250, 3};
        tbl[3]  = '{500,  1, 500,  1, 0, 0, 375, 4};
        tbl[4]  = '{500,  1, 500,  1, 0, 1, 500, 5};
        tbl[5]  = '{500,  1, 500,  1, 0, 1, 500, 6};
        tbl[6]  = '{700,  1, 700,  1, 1, 1, 550, 7};
        tbl[7]  = '{600,  1, 600,  1, 0, 1, 575, 8};
        tbl[8]  = '{250,  1, 250,  3, 1, 1, 512, 9};
        tbl[9]  = '{1200, 1, 1200, 2, 1, 1, 687, 10};
        tbl[10] = '{1200, 1, 1200, 2, 1, 1, 812, 11};
        tbl[11] = '{300,  1, 300,  1, 1, 1, 737, 12};
        tbl[12] = '{1000, 1, 1000, 1, 1, 1, 925, 13};
        tbl[13] = '{1001, 1, 1001, 2, 0, 1, 875, 14};
        tbl[14] = '{299,  1, 299,  3, 1, 1, 650, 15};
        tbl[15] = '{50,   1, 50,   3, 1, 1, 587, 16};
        tbl[16] = '{20,   0, 0,    0, 0, 0, 0,   16};
        tbl[17] = '{480,  1, 500,  1, 0, 1, 462, 17};
        tbl[18] = '{49,   0, 0,    0, 0, 0, 0,   17};
        tbl[19] = '{451,  1, 500,  1, 0, 1, 337, 18};
        tbl[20] = '{421,  1, 421,  1, 0, 1, 367, 19};
        tbl[21] = '{275,  1, 275,  3, 1, 1, 424, 20};

        #1 KEY = 1'b1;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        KEY = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 22; i++)
            do_beat(tbl[i], $sformatf("tbl%0d", i));

        // Silence after the last beat: asystole appears one cycle after cnt hits 4000.
        repeat (3997) @(negedge CLK);
        chk("asys_not_yet", asystole, 0);
        @(negedge CLK);
        chk("asys_set",        asystole,   1);
        chk("asys_avg_valid",  avg_valid,  0);
        chk("asys_rate_class", rate_class, 0);
        chk("asys_isi_avg",    isi_avg,    0);
        chk("asys_beat_cnt",   beat_cnt,   20);

        r = '{0, 0, 0, 0, 0, 0, 0, 21};
        do_beat(r, "asys_clr");
        chk("asys_cleared", asystole, 0);
        r = '{500, 1, 500, 1, 0, 0, 125, 22};
        do_beat(r, "post_asys");

        // Rise exactly when cnt reaches TIMEOUT: the beat wins.
        r = '{4000, 1, 4000, 2, 0, 0, 1125, 23};
        do_beat(r, "edge_at_to");
        chk("edge_at_to_asystole", asystole, 0);

        // Reset mid-interval with spike held high across the release.
        repeat (100) @(negedge CLK);
        spike = 1'b1;
        KEY   = 1'b1;
        @(negedge CLK);
        chk_all_zero("mid_reset");
        repeat (2) @(negedge CLK);
        KEY = 1'b0;
        @(negedge CLK);
        chk("post_rst_beat_cnt",  beat_cnt,  1);
        chk("post_rst_isi_valid", isi_valid, 0);
        chk("post_rst_asystole",  asystole,  0);
        spike = 1'b0;
        repeat (5) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
